oflow_conflict_resolve: RTL and testbench

Resolves ID conflicts after the score board is filled for a frame. Scans all valid score-board rows pairwise and detects rows whose current ID choices collide. For each collision it flips the higher-score (worse-match) row to its second-choice ID through the score board's pointer write port. Rows that have already used both choices are flagged for a fresh ID. Sits downstream of the score-board stage, sharing its read/pointer-write port, and hands `done_cr` to the core FSM before IDs go to the buffer.

---
 rtl/oflow_conflict_resolve_pkg.sv | 20 ++
 rtl/oflow_cr_compare.sv | 23 ++
 rtl/oflow_conflict_resolve.sv | 181 ++++++++++++++++++
 tb/tb_oflow_conflict_resolve.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_conflict_resolve_pkg.sv
// Shared types and sizing for the score-board ID conflict resolver.
// The top module and the compare sub-module both import this package.
package oflow_conflict_resolve_pkg;

  localparam int MAX_ROWS_IN_SCORE_BOARD = 8;
  localparam int ROW_LEN                 = 3;
  localparam int SCORE_LEN               = 8;
  localparam int ID_LEN                  = 8;
  localparam int ID_INVALID              = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    CMP_J,
    WRITE,
    PASS_END,
    DONE
  } cr_state_t;

endpackage

// File: rtl/oflow_cr_compare.sv
// Pairwise ID-collision test between the latched row i and the row j being read.
// Purely combinational; also picks which of the two rows gives up its ID.
module oflow_cr_compare #(
  parameter int SCORE_LEN = oflow_conflict_resolve_pkg::SCORE_LEN,
  parameter int ID_LEN    = oflow_conflict_resolve_pkg::ID_LEN
) (
  input  logic [ID_LEN-1:0]    id_i,
  input  logic [SCORE_LEN-1:0] score_i,
  input  logic [ID_LEN-1:0]    id_j,
  input  logic [SCORE_LEN-1:0] score_j,
  input  logic                 req_i,
  input  logic                 req_j,
  output logic                 conflict,
  output logic                 loser_is_j
);
  import oflow_conflict_resolve_pkg::*;

  // Rows already waiting for a fresh ID no longer compete for their old one.
  assign conflict   = (id_i == id_j) && (id_i != ID_LEN'(ID_INVALID)) && !req_i && !req_j;
  // Higher score is the worse match; on a tie the later row yields.
  assign loser_is_j = !(score_i > score_j);

endmodule

// File: rtl/oflow_conflict_resolve.sv
// Post-fill ID conflict resolver: repeated pairwise passes over the score board,
// flipping losers to their second choice or flagging them for a new ID.
module oflow_conflict_resolve #(
  parameter int MAX_ROWS  = oflow_conflict_resolve_pkg::MAX_ROWS_IN_SCORE_BOARD,
  parameter int ROW_LEN   = oflow_conflict_resolve_pkg::ROW_LEN,
  parameter int SCORE_LEN = oflow_conflict_resolve_pkg::SCORE_LEN,
  parameter int ID_LEN    = oflow_conflict_resolve_pkg::ID_LEN
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 ready_new_frame,
  input  logic                 start_cr,
  input  logic [ROW_LEN:0]     num_of_rows,
  output logic [ROW_LEN-1:0]   row_sel_from_cr,
  input  logic [SCORE_LEN-1:0] score_to_cr,
  input  logic [ID_LEN-1:0]    id_to_cr,
  output logic                 write_to_pointer,
  output logic [ROW_LEN-1:0]   row_to_change,
  output logic                 data_from_cr,
  output logic [MAX_ROWS-1:0]  new_id_req,
  output logic                 done_cr,
  output logic                 busy_cr
);
  import oflow_conflict_resolve_pkg::*;

  localparam logic [ROW_LEN:0] ONE = (ROW_LEN+1)'(1);
  localparam logic [ROW_LEN:0] TWO = (ROW_LEN+1)'(2);

  cr_state_t            state, state_nxt;
  logic [ROW_LEN:0]     n_r, n_nxt;
  logic [ROW_LEN-1:0]   i_r, i_nxt, j_r, j_nxt;
  logic [ROW_LEN-1:0]   loser, loser_r;
  logic                 changed_r, changed_nxt;
  logic [MAX_ROWS-1:0]  flipped_r, flipped_nxt, req_nxt;
  logic [SCORE_LEN-1:0] score_i_r;
  logic [ID_LEN-1:0]    id_i_r;
  logic                 conflict, loser_is_j;
  logic                 j_more, i_more;

  oflow_cr_compare #(
    .SCORE_LEN (SCORE_LEN),
    .ID_LEN    (ID_LEN)
  ) u_compare (
    .id_i       (id_i_r),
    .score_i    (score_i_r),
    .id_j       (id_to_cr),
    .score_j    (score_to_cr),
    .req_i      (new_id_req[i_r]),
    .req_j      (new_id_req[j_r]),
    .conflict   (conflict),
    .loser_is_j (loser_is_j)
  );

  assign loser  = loser_is_j ? j_r : i_r;
  assign j_more = {1'b0, j_r} < (n_r - ONE);
  assign i_more = {1'b0, i_r} < (n_r - TWO);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state      <= IDLE;
      n_r        <= '0;
      i_r        <= '0;
      j_r        <= '0;
      changed_r  <= 1'b0;
      flipped_r  <= '0;
      new_id_req <= '0;
    end else begin
      state      <= state_nxt;
      n_r        <= n_nxt;
      i_r        <= i_nxt;
      j_r        <= j_nxt;
      changed_r  <= changed_nxt;
      flipped_r  <= flipped_nxt;
      new_id_req <= req_nxt;
    end
  end

  // Row-i operands and the loser are plain data; only their capture is state-gated.
  always_ff @(posedge clk) begin
    if (state == LOAD_I) begin
      score_i_r <= score_to_cr;
      id_i_r    <= id_to_cr;
    end
    if (state == CMP_J) begin
      loser_r <= loser;
    end
  end

  always_comb begin
    state_nxt        = state;
    n_nxt            = n_r;
    i_nxt            = i_r;
    j_nxt            = j_r;
    changed_nxt      = changed_r;
    flipped_nxt      = flipped_r;
    req_nxt          = new_id_req;
    row_sel_from_cr  = '0;
    write_to_pointer = 1'b0;
    row_to_change    = '0;
    data_from_cr     = 1'b0;
    done_cr          = 1'b0;
    busy_cr          = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_cr) begin
          n_nxt       = num_of_rows;
          changed_nxt = 1'b0;
          flipped_nxt = '0;
          req_nxt     = '0;
          i_nxt       = '0;
          j_nxt       = ROW_LEN'(1);
          state_nxt   = (num_of_rows <= ONE) ? DONE : LOAD_I;
        end
      end
      LOAD_I: begin
        row_sel_from_cr = i_r;
        state_nxt       = CMP_J;
      end
      CMP_J: begin
        row_sel_from_cr = j_r;
        if (conflict && !flipped_r[loser]) begin
          state_nxt = WRITE;
        end else begin
          if (conflict) begin
            req_nxt[loser] = 1'b1;
            changed_nxt    = 1'b1;
          end
          if (j_more) begin
            j_nxt = j_r + ROW_LEN'(1);
          end else if (i_more) begin
            i_nxt     = i_r + ROW_LEN'(1);
            j_nxt     = i_r + ROW_LEN'(2);
            state_nxt = LOAD_I;
          end else begin
            state_nxt = PASS_END;
          end
        end
      end
      WRITE: begin
        write_to_pointer     = 1'b1;
        row_to_change        = loser_r;
        data_from_cr         = 1'b1;
        flipped_nxt[loser_r] = 1'b1;
        changed_nxt          = 1'b1;
        // Reload row i since it may be the one that just changed its ID.
        if (j_more) begin
          j_nxt     = j_r + ROW_LEN'(1);
          state_nxt = LOAD_I;
        end else if (i_more) begin
          i_nxt     = i_r + ROW_LEN'(1);
          j_nxt     = i_r + ROW_LEN'(2);
          state_nxt = LOAD_I;
        end else begin
          state_nxt = PASS_END;
        end
      end
      PASS_END: begin
        if (changed_r) begin
          changed_nxt = 1'b0;
          i_nxt       = '0;
          j_nxt       = ROW_LEN'(1);
          state_nxt   = LOAD_I;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_cr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (ready_new_frame) begin
      state_nxt   = IDLE;
      changed_nxt = 1'b0;
      flipped_nxt = '0;
      req_nxt     = '0;
    end
  end

endmodule

// File: tb/tb_oflow_conflict_resolve.sv
// Bench for oflow_conflict_resolve: behavioural score board plus a queue-based
// scoreboard whose monitor checks every pointer write and done pulse.
module tb_oflow_conflict_resolve;
  import oflow_conflict_resolve_pkg::*;

  localparam int NR = MAX_ROWS_IN_SCORE_BOARD;

  logic                 clk = 1'b0;
  logic                 reset_N;
  logic                 ready_new_frame;
  logic                 start_cr;
  logic [ROW_LEN:0]     num_of_rows;
  logic [ROW_LEN-1:0]   row_sel_from_cr;
  logic [SCORE_LEN-1:0] score_to_cr;
  logic [ID_LEN-1:0]    id_to_cr;
  logic                 write_to_pointer;
  logic [ROW_LEN-1:0]   row_to_change;
  logic                 data_from_cr;
  logic [NR-1:0]        new_id_req;
  logic                 done_cr;
  logic                 busy_cr;

  logic [ID_LEN-1:0]    sb_id [NR][2];
  logic [SCORE_LEN-1:0] sb_sc [NR][2];
  bit   [NR-1:0]        ptr;
  bit                   clr_ptr;

  typedef struct {
    bit          is_done;
    int          row;
    logic [NR-1:0] req;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  oflow_conflict_resolve dut (
    .clk              (clk),
    .reset_N          (reset_N),
    .ready_new_frame  (ready_new_frame),
    .start_cr         (start_cr),
    .num_of_rows      (num_of_rows),
    .row_sel_from_cr  (row_sel_from_cr),
    .score_to_cr      (score_to_cr),
    .id_to_cr         (id_to_cr),
    .write_to_pointer (write_to_pointer),
    .row_to_change    (row_to_change),
    .data_from_cr     (data_from_cr),
    .new_id_req       (new_id_req),
    .done_cr          (done_cr),
    .busy_cr          (busy_cr)
  );

  // Score board model: combinational read, pointer write at the clock edge.
  assign id_to_cr    = sb_id[row_sel_from_cr][ptr[row_sel_from_cr]];
  assign score_to_cr = sb_sc[row_sel_from_cr][ptr[row_sel_from_cr]];

  always @(posedge clk) begin
    if (clr_ptr) ptr <= '0;
    else if (write_to_pointer) ptr[row_to_change] <= data_from_cr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_N) begin
      if (write_to_pointer) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: row %0d written, required no write", row_to_change);
        end else begin
          e = q.pop_front();
          check("event_is_write", 32'(e.is_done), 32'(0));
          check("row_to_change", 32'(row_to_change), 32'(e.row));
          check("data_from_cr", 32'(data_from_cr), 32'(1));
        end
      end
      if (done_cr) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done_cr at cycle %0d, required none", cyc - start_cyc);
        end else begin
          e = q.pop_front();
          check("event_is_done", 32'(e.is_done), 32'(1));
          check("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
          check("new_id_req_at_done", 32'(new_id_req), 32'(e.req));
        end
      end
    end
  end

  task automatic push_wr(input int row);
    exp_t x;
    x.is_done = 1'b0; x.row = row; x.req = '0; x.lat = 0;
    q.push_back(x);
  endtask

  task automatic push_done(input int lat, input logic [NR-1:0] req);
    exp_t x;
    x.is_done = 1'b1; x.row = 0; x.req = req; x.lat = lat;
    q.push_back(x);
  endtask

  task automatic set_row(input int r, input int id0, input int sc0, input int id1, input int sc1);
    sb_id[r][0] = ID_LEN'(id0);
    sb_sc[r][0] = SCORE_LEN'(sc0);
    sb_id[r][1] = ID_LEN'(id1);
    sb_sc[r][1] = SCORE_LEN'(sc1);
  endtask

  task automatic fresh_board();
    for (int r = 0; r < NR; r++) set_row(r, 100 + r, r, 200 + r, r);
    @(negedge clk);
    clr_ptr = 1'b1;
    @(negedge clk);
    clr_ptr = 1'b0;
  endtask

  task automatic run_start(input int n);
    @(negedge clk);
    num_of_rows = n[ROW_LEN:0];
    start_cr    = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start_cr    = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(q.size()), 32'(0));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_N         = 1'b0;
    ready_new_frame = 1'b0;
    start_cr        = 1'b0;
    num_of_rows     = '0;
    clr_ptr         = 1'b1;
    for (int r = 0; r < NR; r++) set_row(r, 100 + r, r, 200 + r, r);
    repeat (3) @(negedge clk);
    check("reset_write_to_pointer", 32'(write_to_pointer), 32'(0));
    check("reset_done_cr", 32'(done_cr), 32'(0));
    check("reset_busy_cr", 32'(busy_cr), 32'(0));
    check("reset_new_id_req", 32'(new_id_req), 32'(0));
    check("reset_row_sel", 32'(row_sel_from_cr), 32'(0));
    check("reset_row_to_change", 32'(row_to_change), 32'(0));
    check("reset_data_from_cr", 32'(data_from_cr), 32'(0));
    reset_N = 1'b1;
    clr_ptr = 1'b0;
    @(negedge clk);

    // Distinct IDs 5/6/7: one clean pass, no writes.
    fresh_board();
    set_row(0, 5, 1, 50, 1);
    set_row(1, 6, 2, 60, 2);
    set_row(2, 7, 3, 70, 3);
    push_done(7, '0);
    run_start(3);
    drain("drain_distinct");

    // Row 0 has the worse score and moves to its second choice (9).
    fresh_board();
    set_row(0, 4, 10, 9, 20);
    set_row(1, 4, 3, 11, 30);
    push_wr(0);
    push_done(8, '0);
    run_start(2);
    drain("drain_flip_row0");
    check("ptr_row0_after_flip", 32'(ptr[0]), 32'(1));
    check("ptr_row1_untouched", 32'(ptr[1]), 32'(0));

    // Tie: row 1 flips, its second choice collides again, so it is flagged.
    fresh_board();
    set_row(0, 4, 8, 12, 9);
    set_row(1, 4, 8, 4, 8);
    push_wr(1);
    push_done(11, NR'(2));
    run_start(2);
    drain("drain_tie");
    check("new_id_req_holds", 32'(new_id_req), 32'(2));

    // Invalid (zero) IDs never collide; start also clears the previous flag.
    fresh_board();
    set_row(0, 0, 5, 1, 5);
    set_row(1, 0, 7, 2, 7);
    push_done(4, '0);
    run_start(2);
    drain("drain_zero_ids");

    // Abort an 8-row scan with ready_new_frame after its first write.
    fresh_board();
    set_row(0, 4, 8, 30, 8);
    set_row(1, 4, 8, 31, 8);
    push_wr(1);
    run_start(8);
    repeat (4) @(negedge clk);
    ready_new_frame = 1'b1;
    @(negedge clk);
    ready_new_frame = 1'b0;
    check("abort_busy_cr", 32'(busy_cr), 32'(0));
    check("abort_done_cr", 32'(done_cr), 32'(0));
    check("abort_new_id_req", 32'(new_id_req), 32'(0));
    check("abort_row_sel", 32'(row_sel_from_cr), 32'(0));
    repeat (20) @(negedge clk);
    check("abort_queue_empty", 32'(q.size()), 32'(0));

    // Degenerate sizes finish on the cycle after start.
    fresh_board();
    push_done(1, '0);
    run_start(0);
    drain("drain_n0");
    push_done(1, '0);
    run_start(1);
    drain("drain_n1");

    // A second start while busy must not restart or shorten the scan.
    fresh_board();
    push_done(7, '0);
    run_start(3);
    @(negedge clk);
    check("busy_mid_scan", 32'(busy_cr), 32'(1));
    num_of_rows = '0;
    start_cr    = 1'b1;
    @(negedge clk);
    start_cr    = 1'b0;
    drain("drain_start_while_busy");
    repeat (12) @(negedge clk);
    check("idle_after_scan", 32'(busy_cr), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
